shift_seq: RTL and testbench
============================

# shift_seq

Iterative 4-bit shift/rotate engine with valid/ready request and response handshakes. A requester hands it an operand, a shift amount and an opcode. It shifts or rotates one bit position per clock, then holds the result until the consumer takes it. It is the sequential, handshaked counterpart to the team's combinational 4-bit logic unit, for datapaths that need a registered, flow-controlled shift result.

## Interface
- WIDTH, 4, operand/result width; fixed at 4 for this revision
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  engine can accept a request
- req_a  input  4  operand
- req_amt  input  4  unsigned shift amount, 0..15
- req_op  input  3  000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101..111 illegal
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_data  output  4  result
- resp_err  output  1  request carried an illegal opcode
- busy  output  1  engine is in BUSY state

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- Reset values: resp_valid=0, resp_data=0000, resp_err=0, busy=0. req_ready is 0 in any cycle where rst=1.
- req_ready = (state==IDLE) && !rst. It is combinational from state.
- Accept: req_valid && req_ready at a rising edge.
  - On accept, load data<=req_a, op<=req_op, cnt<=N.
- Effective count N:
  - SRL/SLL/SRA: N = min(req_amt, 4). Amounts 4..15 give the fully shifted-out value.
  - ROR/ROL: N = req_amt[1:0]. Upper amount bits are ignored.
  - Illegal opcode: N = 0, err<=1, and data passes through unchanged.
- Next state after accept: BUSY if N>0, else DONE.
- BUSY: each edge applies one 1-bit step to data and decrements cnt. The edge that brings cnt to 0 moves the state to DONE. The step per opcode is:
  - SRL: {0, d[3:1]}
  - SLL: {d[2:0], 0}
  - SRA: {d[3], d[3:1]}
  - ROR: {d[0], d[3:1]}
  - ROL: {d[2:0], d[3]}
- DONE:
  - resp_valid=1.
  - resp_data and resp_err are held stable until resp_ready=1 at an edge; the state then returns to IDLE.
- resp_data/resp_err outputs:
  - Driven from the internal data/err registers, valid only while resp_valid=1.
  - Cleared to 0 on reset.
  - err is cleared on every accept of a legal opcode.
- busy=1 exactly while the state is BUSY.
- req_valid while not IDLE is ignored. No queuing, and no state or data change.
- Inputs are sampled only at the accept edge. Changes to req_* afterwards do not affect the operation in flight.
- Reset mid-operation (BUSY or DONE):
  - Aborts the operation. The result is discarded and never presented.
  - Outputs return to their reset values on that edge.

## Timing
- Handshake cycle is cycle 0. resp_valid first rises in cycle N+1.
  - Latency N+1, range 1..5 cycles.
- With resp_ready already high, the response handshake occurs in cycle N+1.
  - req_ready returns high in cycle N+2.
- Maximum throughput is one operation per N+2 cycles. There is no overlap between response and the next request.
- A request and a response handshake never complete in the same cycle.
- After rst deasserts, req_ready=1 in the first cycle with rst=0.

## Test plan
- SRA, a=1100, amt=0001 → resp_data=1110, resp_err=0, resp_valid in cycle 2, busy high for exactly 1 cycle.
- ROR, a=0111, amt=1001 (N=1) → 1011. ROL, a=0111, amt=1101 (N=1) → 1110. ROR, a=0111, amt=0011 → 1110 with latency 4.
- SLL, a=0101, amt=0011 → 1000, latency 4. SRL, a=1111, amt=0111 saturates at N=4 → 0000, latency 5, busy high for 4 cycles.
- amt=0000, SLL, a=1010 → 1010, latency 1. Illegal op=111, a=0110, amt=0011 → resp_data=0110, resp_err=1, latency 1. A following legal request clears resp_err.
- Backpressure: SRL, a=1000, amt=0001; hold resp_ready=0 for 5 cycles → resp_data=0100 stable, req_ready=0 throughout. A req_valid pulse with a=1111 during the hold is ignored; after release, the next request is accepted normally.
- Assert rst for 1 cycle in the 2nd BUSY cycle of an SLL with amt=0100:
  - resp_valid never rises for that request.
  - resp_data=0000, busy=0.
  - req_ready=1 in the first cycle after rst falls.
  - A new request then completes correctly.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq -- iterative shift/rotate engine with valid/ready handshakes.
//
// Accepts an operand, a shift amount and an opcode. The engine then moves
// the operand one bit position per clock and holds the result until the
// consumer takes it.
//
// Ports:
//   clk        single clock, rising-edge active
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  engine idle and able to accept (forced low while rst=1)
//   req_a      operand
//   req_amt    unsigned shift amount, 0..15
//   req_op     000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, others illegal
//   resp_valid result available (engine in DONE)
//   resp_ready consumer accepts the result
//   resp_data  result
//   resp_err   the request carried an illegal opcode
//   busy       engine is stepping (BUSY state)
module shift_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [3:0]       req_amt,
  input  logic [2:0]       req_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             busy
);

  // Counter must hold 0..WIDTH (shift amounts saturate at WIDTH).
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_SRL = 3'b000,
    OP_SLL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROR = 3'b011,
    OP_ROL = 3'b100
  } op_e;

  state_e           state, state_next;
  logic [WIDTH-1:0] data,  data_next;
  logic [2:0]       op,    op_next;
  logic [CW-1:0]    cnt,   cnt_next;
  logic             err,   err_next;

  logic [CW-1:0]    eff_cnt;
  logic             illegal;

  // One bit-position step for the given opcode.
  function automatic logic [WIDTH-1:0] shift_step(input logic [2:0] f_op,
                                                  input logic [WIDTH-1:0] d);
    case (f_op)
      OP_SRL:  shift_step = {1'b0, d[WIDTH-1:1]};
      OP_SLL:  shift_step = {d[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_step = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROR:  shift_step = {d[0], d[WIDTH-1:1]};
      OP_ROL:  shift_step = {d[WIDTH-2:0], d[WIDTH-1]};
      default: shift_step = d;
    endcase
  endfunction

  // Effective step count. Shifts saturate: beyond WIDTH steps nothing changes.
  // Rotates are periodic in WIDTH, so only the low amount bits matter.
  // Illegal opcodes take zero steps and pass the operand through.
  always_comb begin
    eff_cnt = '0;
    illegal = 1'b0;
    case (req_op)
      OP_SRL, OP_SLL, OP_SRA:
        eff_cnt = (req_amt >= 4'(WIDTH)) ? CW'(WIDTH) : CW'(req_amt);
      OP_ROR, OP_ROL:
        eff_cnt = CW'(req_amt[$clog2(WIDTH)-1:0]);
      default:
        illegal = 1'b1;
    endcase
  end

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    data_next  = data;
    op_next    = op;
    cnt_next   = cnt;
    err_next   = err;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          data_next  = req_a;
          op_next    = req_op;
          cnt_next   = eff_cnt;
          err_next   = illegal;
          state_next = (eff_cnt == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        data_next = shift_step(op, data);
        cnt_next  = cnt - 1'b1;
        if (cnt == CW'(1)) state_next = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      data  <= '0;
      op    <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      data  <= data_next;
      op    <= op_next;
      cnt   <= cnt_next;
      err   <= err_next;
    end
  end

  // req_ready also looks at rst so no request is taken on a reset edge.
  assign req_ready  = (state == S_IDLE) && !rst;
  assign resp_valid = (state == S_DONE);
  assign busy       = (state == S_BUSY);
  assign resp_data  = data;
  assign resp_err   = err;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq -- directed self-checking bench for shift_seq.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shift_seq;

  localparam logic [2:0] SRL = 3'b000;
  localparam logic [2:0] SLL = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROR = 3'b011;
  localparam logic [2:0] ROL = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_a = '0;
  logic [3:0] req_amt = '0;
  logic [2:0] req_op = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [3:0] resp_data;
  logic       resp_err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  shift_seq #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_amt    (req_amt),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Issues one request with resp_ready high and reports what came back.
  // Cycle 0 is the request handshake cycle; lat is the first cycle with
  // resp_valid=1 (-1 if it never rose). req_* are scrambled after the accept.
  task automatic do_req(input logic [3:0] a, input logic [3:0] amt,
                        input logic [2:0] op, output logic [3:0] d,
                        output logic e, output int lat, output int nbusy);
    d = 'x; e = 1'bx; lat = -1; nbusy = 0;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_amt = amt; req_op = op;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = ~a; req_amt = ~amt; req_op = 3'b111;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (resp_valid) begin
        d = resp_data; e = resp_err; lat = k;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    vectors++;
    if (resp_data !== 4'b0000) begin miscompares++; $display("FAIL reset_resp_data: got %b want 0000", resp_data); end
    vectors++;
    if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] amt;
    logic [3:0] exp_d;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  task automatic test_shifts;
    vec_t tbl[9] = '{
      '{SRA, 4'b1100, 4'b0001, 4'b1110, 2, 1},
      '{ROR, 4'b0111, 4'b1001, 4'b1011, 2, 1},
      '{ROL, 4'b0111, 4'b1101, 4'b1110, 2, 1},
      '{ROR, 4'b0111, 4'b0011, 4'b1110, 4, 3},
      '{SLL, 4'b0101, 4'b0011, 4'b1000, 4, 3},
      '{SRL, 4'b1111, 4'b0111, 4'b0000, 5, 4},
      '{SLL, 4'b1010, 4'b0000, 4'b1010, 1, 0},
      '{SRA, 4'b1000, 4'b1111, 4'b1111, 5, 4},
      '{ROL, 4'b1001, 4'b0110, 4'b0110, 3, 2}
    };
    logic [3:0] d;
    logic       e;
    int         lat, nb;
    foreach (tbl[i]) begin
      do_req(tbl[i].a, tbl[i].amt, tbl[i].op, d, e, lat, nb);
      vectors++;
      if (d !== tbl[i].exp_d) begin miscompares++; $display("FAIL shift%0d_data: got %b want %b", i, d, tbl[i].exp_d); end
      vectors++;
      if (e !== 1'b0) begin miscompares++; $display("FAIL shift%0d_err: got %b want 0", i, e); end
      vectors++;
      if (lat != tbl[i].exp_lat) begin miscompares++; $display("FAIL shift%0d_latency: got %0d want %0d", i, lat, tbl[i].exp_lat); end
      vectors++;
      if (nb != tbl[i].exp_busy) begin miscompares++; $display("FAIL shift%0d_busy_cycles: got %0d want %0d", i, nb, tbl[i].exp_busy); end
    end
  endtask

  task automatic test_illegal;
    logic [3:0] d;
    logic       e;
    int         lat, nb;
    do_req(4'b0110, 4'b0011, 3'b111, d, e, lat, nb);
    vectors++;
    if (d !== 4'b0110) begin miscompares++; $display("FAIL illegal_data: got %b want 0110", d); end
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b want 1", e); end
    vectors++;
    if (lat != 1) begin miscompares++; $display("FAIL illegal_latency: got %0d want 1", lat); end
    vectors++;
    if (nb != 0) begin miscompares++; $display("FAIL illegal_busy_cycles: got %0d want 0", nb); end
    do_req(4'b1001, 4'b0010, 3'b101, d, e, lat, nb);
    vectors++;
    if (d !== 4'b1001 || e !== 1'b1) begin miscompares++; $display("FAIL illegal101: got %b/%b want 1001/1", d, e); end
    do_req(4'b0001, 4'b0001, SRL, d, e, lat, nb);
    vectors++;
    if (d !== 4'b0000 || e !== 1'b0) begin miscompares++; $display("FAIL illegal_then_legal: got %b/%b want 0000/0", d, e); end
    vectors++;
    if (lat != 2) begin miscompares++; $display("FAIL illegal_then_legal_latency: got %0d want 2", lat); end
  endtask

  task automatic test_backpressure;
    int         lat;
    logic [3:0] d;
    logic       e;
    int         nb;
    lat = -1;
    @(negedge clk);
    req_valid = 1'b1; req_a = 4'b1000; req_amt = 4'b0001; req_op = SRL;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin lat = k; break; end
    end
    vectors++;
    if (lat != 2) begin miscompares++; $display("FAIL bp_latency: got %0d want 2", lat); end
    for (int h = 0; h < 5; h++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_data !== 4'b0100 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got valid=%b data=%b err=%b rdy=%b want 1 0100 0 0",
                 h, resp_valid, resp_data, resp_err, req_ready);
      end
      if (h == 1) begin
        req_valid = 1'b1; req_a = 4'b1111; req_amt = 4'b0001; req_op = SLL;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got valid=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    do_req(4'b0011, 4'b0001, SLL, d, e, lat, nb);
    vectors++;
    if (d !== 4'b0110 || lat != 2) begin miscompares++; $display("FAIL bp_next: got %b lat %0d want 0110 lat 2", d, lat); end
  endtask

  task automatic test_reset_mid;
    logic [3:0] d;
    logic       e;
    int         lat, nb;
    bit         seen_valid;
    @(negedge clk);
    req_valid = 1'b1; req_a = 4'b0011; req_amt = 4'b0100; req_op = SLL;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (resp_valid !== 1'b0 || resp_data !== 4'b0000 || busy !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got valid=%b data=%b busy=%b rdy=%b want 0 0000 0 0",
               resp_valid, resp_data, busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    seen_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) seen_valid = 1'b1;
    end
    vectors++;
    if (seen_valid) begin miscompares++; $display("FAIL midrst_no_resp: got resp_valid=1 want 0"); end
    do_req(4'b0011, 4'b0001, ROL, d, e, lat, nb);
    vectors++;
    if (d !== 4'b0110 || e !== 1'b0 || lat != 2) begin
      miscompares++;
      $display("FAIL midrst_next: got %b/%b lat %0d want 0110/0 lat 2", d, e, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_a = 4'b0001; req_amt = 4'b0001; req_op = SLL;
    resp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b want 1", busy); end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 4'b0010 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first_resp: got valid=%b data=%b rdy=%b want 1 0010 0", resp_valid, resp_data, req_ready);
    end
    req_a = 4'b0010;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_turnaround: got rdy=%b valid=%b want 1 0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin lat = k; break; end
    end
    vectors++;
    if (lat != 2 || resp_data !== 4'b0100) begin
      miscompares++;
      $display("FAIL b2b_second: got lat %0d data %b want lat 2 data 0100", lat, resp_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
